// File: rtl/element_cmd_issuer_if.sv
// element_cmd_issuer_if: command-source and element-side signal bundle for element_cmd_issuer
// master: issuer view (drives cmd_ready, cmdstb, held fields, late, late_cnt, pending)
// slave: counterpart view (drives cmd, cmd_valid, flush, tcnt, busy)
interface element_cmd_issuer_if #(
  parameter int ENV_ADDRWIDTH = 12,
  parameter int FREQ_ADDRWIDTH = 9,
  parameter int TCNTWIDTH = 27,
  parameter int DEPTH = 4
);
  logic [127:0] cmd;
  logic cmd_valid, cmd_ready, flush, busy, cmdstb, late;
  logic [TCNTWIDTH-1:0] tcnt;
  logic [ENV_ADDRWIDTH-1:0] envstart, envlength;
  logic [15:0] ampx, late_cnt;
  logic [16:0] pini;
  logic [FREQ_ADDRWIDTH-1:0] freqaddr;
  logic [1:0] mode;
  logic [$clog2(DEPTH):0] pending;
  modport master (
    input cmd, cmd_valid, flush, tcnt, busy,
    output cmd_ready, cmdstb, envstart, envlength, ampx, pini, freqaddr, mode, late, late_cnt, pending
  );
  modport slave (
    output cmd, cmd_valid, flush, tcnt, busy,
    input cmd_ready, cmdstb, envstart, envlength, ampx, pini, freqaddr, mode, late, late_cnt, pending
  );
endinterface

// File: rtl/element_cmd_issuer.sv
// element_cmd_issuer: buffers timestamped pulse commands and issues each to one element once due and not busy
// Ports: clk; reset (async, active-high); io (element_cmd_issuer_if.master): cmd/cmd_valid/cmd_ready/flush
// from the command source, tcnt/busy from the element, cmdstb with held fields, late/late_cnt and pending out.
module element_cmd_issuer #(
  parameter int ENV_ADDRWIDTH = 12,
  parameter int FREQ_ADDRWIDTH = 9,
  parameter int TCNTWIDTH = 27,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  element_cmd_issuer_if.master io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ISSUE = 2'd2, GAP = 2'd3;
  logic [94:0] mem_q [DEPTH];
  logic [94:0] stg_q;
  logic [AW:0] wr_q, rd_q, cnt, cnt_d;
  logic [1:0] st_q, st_d;
  logic gap_q, rdy_q, stb_q, late_q;
  logic [ENV_ADDRWIDTH-1:0] es_q, el_q;
  logic [15:0] ax_q, lcnt_q;
  logic [16:0] pi_q;
  logic [FREQ_ADDRWIDTH-1:0] fa_q;
  logic [1:0] md_q;
  logic [TCNTWIDTH-1:0] diff;
  logic push, load, fire, late_d, unused_hi;
  assign unused_hi = ^io.cmd[127:95];
  assign cnt = wr_q - rd_q;
  assign push = io.cmd_valid & rdy_q & ~io.flush;
  // the last GAP cycle already stages the next command, giving the 4-cycle minimum issue spacing
  assign load = (st_q == IDLE || (st_q == GAP && gap_q)) && cnt != '0 && !io.flush;
  // modular difference: a trigger up to half the counter range behind tcnt is due, across the wrap
  assign diff = io.tcnt - stg_q[TCNTWIDTH-1:0];
  assign fire = st_q == WAIT && !diff[TCNTWIDTH-1] && !io.busy && !io.flush;
  assign late_d = io.tcnt != stg_q[TCNTWIDTH-1:0];
  assign cnt_d = io.flush ? '0 : cnt + (AW+1)'(push) - (AW+1)'(load);
  assign st_d = load ? WAIT :
                st_q == WAIT ? (io.flush ? IDLE : fire ? ISSUE : WAIT) :
                st_q == ISSUE ? GAP :
                (st_q == GAP && gap_q) ? IDLE : st_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= io.cmd[94:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      gap_q <= 1'b0;
      rdy_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      stg_q <= '0;
      stb_q <= 1'b0;
      late_q <= 1'b0;
      lcnt_q <= '0;
      es_q <= '0;
      el_q <= '0;
      ax_q <= '0;
      pi_q <= '0;
      fa_q <= '0;
      md_q <= '0;
    end else begin
      st_q <= st_d;
      gap_q <= st_q == GAP && !gap_q;
      rdy_q <= cnt_d < (AW+1)'(DEPTH);
      wr_q <= wr_q + (AW+1)'(push);
      rd_q <= io.flush ? wr_q : rd_q + (AW+1)'(load);
      if (load) stg_q <= mem_q[rd_q[AW-1:0]];
      stb_q <= fire;
      late_q <= fire & late_d;
      if (fire) begin
        es_q <= stg_q[27 +: ENV_ADDRWIDTH];
        el_q <= stg_q[39 +: ENV_ADDRWIDTH];
        ax_q <= stg_q[66:51];
        pi_q <= stg_q[83:67];
        fa_q <= stg_q[84 +: FREQ_ADDRWIDTH];
        md_q <= stg_q[94:93];
        if (late_d && lcnt_q != '1) lcnt_q <= lcnt_q + 16'd1;
      end
    end
  assign io.cmd_ready = rdy_q;
  assign io.pending = cnt;
  assign io.cmdstb = stb_q;
  assign io.late = late_q;
  assign io.late_cnt = lcnt_q;
  assign io.envstart = es_q;
  assign io.envlength = el_q;
  assign io.ampx = ax_q;
  assign io.pini = pi_q;
  assign io.freqaddr = fa_q;
  assign io.mode = md_q;
endmodule
